mem_writeback_top: RTL
======================

# mem_writeback_top

Back half of the pipeline: accepts the execute-stage result bundle, performs the data-memory access through a request/ready handshake, and returns the register-file write port (`write_en`, `write_id`, `write_data`) and both forwarding values (`mem_forward_data`, `wb_forward_data`) to the decode/execute front end. It contains the EX/MEM and MEM/WB pipeline registers and the load/store lane logic. It stalls the front end while a memory access is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 16: wait cycles before an access is aborted (used only with the timeout feature).
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ex_valid`  in  1  execute bundle valid this cycle.
- `ex_control`  in  control_type  execute control; consumes `reg_write`, `mem_read`, `mem_write`, `mem_to_reg`, `funct3`.
- `ex_rd_id`  in  5  destination register.
- `ex_alu_data`  in  32  ALU result / memory address.
- `ex_memory_data`  in  32  store data (rs2).
- `mem_stall`  out  1  front end must hold its outputs.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  32  word-aligned address (`[1:0]` = 0).
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_be`  out  4  byte enables.
- `dmem_ready`  in  1  transfer completes at this edge.
- `dmem_rdata`  in  32  load word, valid with `dmem_ready`.
- `write_en`  out  1  register-file write.
- `write_id`  out  5  register-file index.
- `write_data`  out  32  register-file data.
- `mem_forward_data`  out  32  EX/MEM ALU result.
- `wb_forward_data`  out  32  equals `write_data`.
- `mem_fault`  out  1  one-cycle pulse: misaligned access or timeout.

## Operation
- **EX/MEM register.** Loads `ex_*` when `mem_stall` = 0. It loads valid = 0 when `ex_valid` = 0.
- **Memory op.** A memory op is a valid EX/MEM entry with `mem_read` or `mem_write` set.
- **Alignment.**
  - Halfword requires `addr[0]` = 0.
  - Word requires `addr[1:0]` = 0.
  - A misaligned op issues no request, pulses `mem_fault`, and retires as a bubble (no register write).
- **Stores.** `funct3` 0/1/2 = SB/SH/SW.
  - `dmem_wdata`: byte replicated ×4, or halfword replicated ×2.
  - `dmem_be`: SB = `0001 << addr[1:0]`; SH = `0011 << addr[1:0]`; SW = `1111`.
- **Loads.** `funct3` 0/1/2/4/5 = LB/LH/LW/LBU/LHU.
  - The lane is selected by `addr[1:0]`, then sign- or zero-extended.
  - `dmem_be` is set as for stores.
- **FSM states.**
  - IDLE: `dmem_req` is asserted combinationally when a memory op is present.
  - WAIT: `dmem_req` is held.
- **FSM transitions.**
  - IDLE → WAIT if the request is not accepted.
  - WAIT → IDLE on `dmem_ready`.
  - `dmem_addr`, `dmem_we`, `dmem_wdata` and `dmem_be` stay stable while `dmem_req` = 1.
- **Stall.** `mem_stall` = valid memory op ∧ ¬(`dmem_req` ∧ `dmem_ready`) ∧ ¬fault.
- **MEM/WB register.** Loads when the entry completes.
  - `write_en` = valid ∧ `reg_write` ∧ (`rd` ≠ 0).
  - `write_data` = `mem_to_reg` ? extended load : ALU result.
  - While stalled, it loads a bubble (`write_en` = 0; `write_id` and `write_data` hold).
- **Non-memory entries.** They complete in one cycle without touching the handshake.

## Timing
- **Reset values.**
  - All outputs are 0.
  - Both pipeline registers are invalid and zeroed.
  - FSM is in IDLE.
  - The asynchronous assertion drops `dmem_req` immediately, including mid-access; the pending transfer is abandoned.
- **Non-memory latency.** An entry captured at edge N drives `write_*` after edge N+1.
- **Zero-wait memory.** With `dmem_ready` = 1 in the request cycle, the latency equals the non-memory case and `mem_stall` never asserts.
- **k wait cycles.** `mem_stall` is high for k cycles and `write_*` is delayed by k.
- **Back-to-back memory ops.** A new request is issued in the cycle after completion, with no idle gap beyond IDLE re-entry.
- **Forwarding.**
  - `mem_forward_data` is registered (EX/MEM).
  - `wb_forward_data` is registered (MEM/WB).
  - Both are valid regardless of stall.
- **Write/decode read same cycle.** The register-file bypass is the front end's responsibility; this block gives no extra guarantee.

## Configuration
- **`MEM_ACCESS_TIMEOUT_EN` defined.**
  - An 8-bit wait counter runs in WAIT and clears on leaving WAIT or on reset.
  - At count = `TIMEOUT_CYCLES` − 1 the FSM returns to IDLE, drops `dmem_req`, pulses `mem_fault`, and retires a bubble.
- **Undefined.** No counter; WAIT persists until `dmem_ready`, and `mem_fault` reports misalignment only.

## Test plan
- **ALU write.** `ex_valid`, `reg_write`, rd = 5, alu = 0x1234 → 2 edges later `write_en` = 1, `write_id` = 5, `write_data` = 0x1234; `mem_stall` never high.
- **SB.** SB, addr 0x103, data 0xAB → `dmem_addr` = 0x100, `dmem_be` = 1000, `dmem_wdata` = 0xABABABAB, `dmem_we` = 1; no register write.
- **LB / LBU with wait states.**
  - LB addr 0x102, rdata 0x00800000, ready after 3 wait cycles → `mem_stall` high 3 cycles, then `write_data` = 0xFFFFFF80.
  - LBU with the same stimulus → 0x00000080.
- **Misaligned LW.** LW addr 0x102 → no `dmem_req`, `mem_fault` 1-cycle pulse, `write_en` stays 0.
- **rd = 0.** Load to rd = 0 → memory access performed, `write_en` = 0.
- **Timeout (`MEM_ACCESS_TIMEOUT_EN` defined).**
  - `dmem_ready` held 0 → `dmem_req` drops after 16 cycles, `mem_fault` pulses, the stall releases.
  - Separately, `reset` asserted mid-WAIT → `dmem_req` = 0 immediately.

Source files
------------

// File: rtl/mem_writeback_top.sv
// mem_writeback_top: MEM and WB stages of the pipeline.
// Holds the EX/MEM and MEM/WB registers, runs the data-memory handshake,
// does load/store lane steering, and stalls the front end while an access
// is outstanding.
//
// ex_control layout: [6] reg_write, [5] mem_read, [4] mem_write,
//                    [3] mem_to_reg, [2:0] funct3.
//
// Handshake: dmem_req stays high, with addr/we/wdata/be stable, until an
// edge where dmem_ready is also high; that edge completes the transfer and
// dmem_rdata is taken from the same cycle.
//
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort an access that
// has waited TIMEOUT_CYCLES cycles (fault pulse, bubble retired).
module mem_writeback_top #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [6:0]  ex_control,
   input  logic [4:0]  ex_rd_id,
   input  logic [31:0] ex_alu_data,
   input  logic [31:0] ex_memory_data,
   output logic        mem_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        write_en,
   output logic [4:0]  write_id,
   output logic [31:0] write_data,
   output logic [31:0] mem_forward_data,
   output logic [31:0] wb_forward_data,
   output logic        mem_fault,
   output logic        fsm_state
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t      state;
   logic        em_valid, em_reg_write, em_mem_read, em_mem_write, em_mem_to_reg;
   logic [2:0]  em_funct3;
   logic [4:0]  em_rd;
   logic [31:0] em_alu, em_store;

   logic        mem_op, misaligned, access_fault, timeout_hit;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata, load_ext;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

`ifdef MEM_ACCESS_TIMEOUT_EN
   logic [7:0] wait_cnt;
   assign timeout_hit = (state == WAIT) && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   assign mem_op       = em_valid & (em_mem_read | em_mem_write);
   assign access_fault = mem_op & (misaligned | timeout_hit);
   // A faulting entry retires immediately, so it never holds the stall.
   assign dmem_req     = mem_op & ~misaligned & ~timeout_hit;
   assign mem_stall    = mem_op & ~(dmem_req & dmem_ready) & ~access_fault;
   assign mem_fault    = access_fault;
   assign fsm_state    = state;

   // Memory-side outputs are zero whenever no request is presented.
   assign dmem_we    = dmem_req & em_mem_write;
   assign dmem_addr  = dmem_req ? {em_alu[31:2], 2'b00} : 32'd0;
   assign dmem_be    = dmem_req ? lane_be : 4'd0;
   assign dmem_wdata = dmem_req ? lane_wdata : 32'd0;

   assign mem_forward_data = em_alu;
   assign wb_forward_data  = write_data;

   // Access size from funct3[1:0]: alignment check, byte enables, store data.
   always_comb begin
      misaligned = 1'b0;
      lane_be    = 4'b1111;
      lane_wdata = em_store;
      case (em_funct3[1:0])
         2'b00: begin
            lane_be    = 4'b0001 << em_alu[1:0];
            lane_wdata = {4{em_store[7:0]}};
         end
         2'b01: begin
            misaligned = em_alu[0];
            lane_be    = 4'b0011 << em_alu[1:0];
            lane_wdata = {2{em_store[15:0]}};
         end
         default: begin
            misaligned = |em_alu[1:0];
         end
      endcase
   end

   // Load lane selection and sign/zero extension.
   always_comb begin
      case (em_alu[1:0])
         2'b00:   lane_byte = dmem_rdata[7:0];
         2'b01:   lane_byte = dmem_rdata[15:8];
         2'b10:   lane_byte = dmem_rdata[23:16];
         default: lane_byte = dmem_rdata[31:24];
      endcase
      lane_half = em_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (em_funct3)
         3'd0:    load_ext = {{24{lane_byte[7]}}, lane_byte};
         3'd1:    load_ext = {{16{lane_half[15]}}, lane_half};
         3'd4:    load_ext = {24'd0, lane_byte};
         3'd5:    load_ext = {16'd0, lane_half};
         default: load_ext = dmem_rdata;
      endcase
   end

   // EX/MEM register: captures the execute bundle whenever not stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         em_valid      <= 1'b0;
         em_reg_write  <= 1'b0;
         em_mem_read   <= 1'b0;
         em_mem_write  <= 1'b0;
         em_mem_to_reg <= 1'b0;
         em_funct3     <= 3'd0;
         em_rd         <= 5'd0;
         em_alu        <= 32'd0;
         em_store      <= 32'd0;
      end else if (!mem_stall) begin
         em_valid      <= ex_valid;
         em_reg_write  <= ex_control[6];
         em_mem_read   <= ex_control[5];
         em_mem_write  <= ex_control[4];
         em_mem_to_reg <= ex_control[3];
         em_funct3     <= ex_control[2:0];
         em_rd         <= ex_rd_id;
         em_alu        <= ex_alu_data;
         em_store      <= ex_memory_data;
      end
   end

   // Handshake FSM: IDLE issues, WAIT holds the request until ready (or timeout).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
`ifdef MEM_ACCESS_TIMEOUT_EN
         wait_cnt <= 8'd0;
`endif
      end else begin
         case (state)
            IDLE:    if (dmem_req && !dmem_ready) state <= WAIT;
            default: if (dmem_ready || timeout_hit) state <= IDLE;
         endcase
`ifdef MEM_ACCESS_TIMEOUT_EN
         if (state == WAIT && !dmem_ready && !timeout_hit)
            wait_cnt <= wait_cnt + 8'd1;
         else
            wait_cnt <= 8'd0;
`endif
      end
   end

   // MEM/WB register: retires the entry when it completes, bubbles otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_en   <= 1'b0;
         write_id   <= 5'd0;
         write_data <= 32'd0;
      end else if (mem_stall) begin
         write_en <= 1'b0;
      end else begin
         write_en <= em_valid & em_reg_write & (em_rd != 5'd0) & ~access_fault;
         if (em_valid && !access_fault) begin
            write_id   <= em_rd;
            write_data <= em_mem_to_reg ? load_ext : em_alu;
         end
      end
   end

endmodule
